// File: rtl/md_sched_e_pkg.sv
// Shared encodings and helpers for the E-stage multiply/divide scheduler.
package md_sched_e_pkg;

    // MDOp encodings presented by the E stage
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_t;

    // Scheduler FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // True for the operations that occupy the unit for a multi-cycle period
    function automatic logic is_md_arith(input logic [2:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_sched_e_if.sv
// E-stage issue / HI-LO result bundle between the pipeline and the MD scheduler.
interface md_sched_e_if;
    logic        start_e;   // E-stage instruction is MD-class and valid
    logic [2:0]  md_op;     // MDOp encoding
    logic [31:0] src_a;     // rs operand, forwarded
    logic [31:0] src_b;     // rt operand, forwarded
    logic        md_use_d;  // D-stage instruction touches HI/LO
    logic        busy;      // unit counting, HI/LO not final
    logic        stall_md;  // stall request for F/D
    logic [31:0] hi;        // architectural HI
    logic [31:0] lo;        // architectural LO

    modport master (output start_e, md_op, src_a, src_b, md_use_d,
                    input  busy, stall_md, hi, lo);
    modport slave  (input  start_e, md_op, src_a, src_b, md_use_d,
                    output busy, stall_md, hi, lo);
endinterface

// File: rtl/md_sched_e_calc.sv
// Combinational multiply/divide core producing a 64-bit {hi,lo} result and a divide-by-zero flag.
module md_calc
    import md_sched_e_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);
    logic signed [63:0] sa_s;
    logic signed [63:0] sb_s;
    logic signed [63:0] sprod_s;
    logic [63:0]        uprod_s;
    logic               sdiv_s;
    logic [31:0]        num_mag_s;
    logic [31:0]        den_mag_s;
    logic [31:0]        den_safe_s;
    logic [31:0]        q_mag_s;
    logic [31:0]        r_mag_s;

    // Products and sign-magnitude division (avoids the INT_MIN / -1 trap; the wrap yields 0x80000000)
    always_comb begin
        sa_s       = {{32{a[31]}}, a};
        sb_s       = {{32{b[31]}}, b};
        sprod_s    = sa_s * sb_s;
        uprod_s    = {32'd0, a} * {32'd0, b};
        sdiv_s     = (op == MD_DIV);
        num_mag_s  = (sdiv_s && a[31]) ? (~a + 32'd1) : a;
        den_mag_s  = (sdiv_s && b[31]) ? (~b + 32'd1) : b;
        den_safe_s = (b == 32'd0) ? 32'd1 : den_mag_s;
        q_mag_s    = num_mag_s / den_safe_s;
        r_mag_s    = num_mag_s % den_safe_s;
    end

    // Result selection per operation
    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
        case (op)
            MD_MULT: begin
                hi = sprod_s[63:32];
                lo = sprod_s[31:0];
            end
            MD_MULTU: begin
                hi = uprod_s[63:32];
                lo = uprod_s[31:0];
            end
            MD_DIV: begin
                div0 = (b == 32'd0);
                lo   = (a[31] ^ b[31]) ? (~q_mag_s + 32'd1) : q_mag_s;
                hi   = a[31] ? (~r_mag_s + 32'd1) : r_mag_s;
            end
            MD_DIVU: begin
                div0 = (b == 32'd0);
                lo   = q_mag_s;
                hi   = r_mag_s;
            end
            default: begin
                hi   = 32'd0;
                lo   = 32'd0;
                div0 = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/md_sched_e.sv
// Multi-cycle MULT/DIV scheduler beside the E-stage ALU; owns HI/LO and requests F/D stalls.
module md_sched_e
    import md_sched_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    md_sched_e_if.slave  bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_t          state_r;
    md_state_t          state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [63:0]        pend_r;
    logic               pend_div0_r;
    logic [31:0]        hi_r;
    logic [31:0]        lo_r;
    logic               load_s;
    logic               commit_s;
    logic [31:0]        calc_hi_s;
    logic [31:0]        calc_lo_s;
    logic               calc_div0_s;

    md_calc u_calc (
        .op   (bus.md_op),
        .a    (bus.src_a),
        .b    (bus.src_b),
        .hi   (calc_hi_s),
        .lo   (calc_lo_s),
        .div0 (calc_div0_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Next-state and load/commit strobes
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_e && is_md_arith(bus.md_op)) begin
                    load_s     = 1'b1;
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_W'(1)) begin
                    commit_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Latency counter and pending result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= '0;
            pend_r      <= 64'd0;
            pend_div0_r <= 1'b0;
        end else if (load_s) begin
            cnt_r       <= (bus.md_op == MD_DIV || bus.md_op == MD_DIVU) ?
                           CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_r      <= {calc_hi_s, calc_lo_s};
            pend_div0_r <= calc_div0_s;
        end else if (commit_s) begin
            cnt_r       <= '0;
        end else if (state_r == ST_BUSY) begin
            cnt_r       <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r       <= cnt_r;
        end
    end

    // Architectural HI/LO: direct moves in IDLE, pending commit at end of busy period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            if (!pend_div0_r) begin
                hi_r <= pend_r[63:32];
                lo_r <= pend_r[31:0];
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else if (state_r == ST_IDLE && bus.start_e && bus.md_op == MD_MTHI) begin
            hi_r <= bus.src_a;
        end else if (state_r == ST_IDLE && bus.start_e && bus.md_op == MD_MTLO) begin
            lo_r <= bus.src_a;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign bus.busy     = (state_r == ST_BUSY);
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.stall_md = bus.md_use_d &
                          ((state_r == ST_BUSY) || (bus.start_e && is_md_arith(bus.md_op)));
endmodule

// File: tb/tb_md_sched_e.sv
// Directed self-checking bench for md_sched_e.
module tb_md_sched_e;
    import md_sched_e_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    md_sched_e_if bus ();

    md_sched_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op and check busy/stall across its whole period
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_d, input int n);
        bus.start_e  = 1'b1;
        bus.md_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.md_use_d = use_d;
        #1;
        check({tag, " stall@start"}, {31'd0, bus.stall_md}, {31'd0, use_d});
        check({tag, " busy@start"},  {31'd0, bus.busy},     32'd0);
        tick();
        bus.start_e = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s busy c%0d", tag, i),  {31'd0, bus.busy},     32'd1);
            check($sformatf("%s stall c%0d", tag, i), {31'd0, bus.stall_md}, {31'd0, use_d});
            tick();
        end
        check({tag, " busy fall"},  {31'd0, bus.busy},     32'd0);
        check({tag, " stall fall"}, {31'd0, bus.stall_md}, 32'd0);
        bus.md_use_d = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        bus.start_e  = 1'b0;
        bus.md_op    = 3'b000;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.md_use_d = 1'b0;
        tick();
        tick();
        check("reset busy",  {31'd0, bus.busy},     32'd0);
        check("reset stall", {31'd0, bus.stall_md}, 32'd0);
        check("reset hi",    bus.hi, 32'd0);
        check("reset lo",    bus.lo, 32'd0);
        reset = 1'b1;
        tick();

        // MULT signed: -1 * 2 = -2
        issue("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 5);
        check("mult hi", bus.hi, 32'hFFFF_FFFF);
        check("mult lo", bus.lo, 32'hFFFF_FFFE);

        // MULTU: 0xFFFFFFFF * 2, no D-stage user so no stall
        issue("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 5);
        check("multu hi", bus.hi, 32'h0000_0001);
        check("multu lo", bus.lo, 32'hFFFF_FFFE);

        // DIV: -7 / 2 = -3 rem -1
        issue("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
        check("div lo", bus.lo, 32'hFFFF_FFFD);
        check("div hi", bus.hi, 32'hFFFF_FFFF);

        // DIVU by zero leaves HI/LO untouched
        issue("divu0", MD_DIVU, 32'd1234, 32'd0, 1'b0, 10);
        check("divu0 lo", bus.lo, 32'hFFFF_FFFD);
        check("divu0 hi", bus.hi, 32'hFFFF_FFFF);

        // DIVU ordinary: 100 / 7 = 14 rem 2
        issue("divu", MD_DIVU, 32'd100, 32'd7, 1'b0, 10);
        check("divu lo", bus.lo, 32'd14);
        check("divu hi", bus.hi, 32'd2);

        // DIV overflow corner
        issue("divov", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10);
        check("divov lo", bus.lo, 32'h8000_0000);
        check("divov hi", bus.hi, 32'h0000_0000);

        // MTHI in IDLE with a D-stage user present: no busy, no stall
        bus.start_e  = 1'b1;
        bus.md_op    = MD_MTHI;
        bus.src_a    = 32'h1234_5678;
        bus.md_use_d = 1'b1;
        #1;
        check("mthi stall@start", {31'd0, bus.stall_md}, 32'd0);
        tick();
        bus.start_e = 1'b0;
        check("mthi hi",    bus.hi, 32'h1234_5678);
        check("mthi lo",    bus.lo, 32'h8000_0000);
        check("mthi busy",  {31'd0, bus.busy},     32'd0);
        check("mthi stall", {31'd0, bus.stall_md}, 32'd0);
        bus.md_use_d = 1'b0;

        // MTLO
        bus.start_e = 1'b1;
        bus.md_op   = MD_MTLO;
        bus.src_a   = 32'hCAFE_F00D;
        tick();
        bus.start_e = 1'b0;
        check("mtlo lo",   bus.lo, 32'hCAFE_F00D);
        check("mtlo hi",   bus.hi, 32'h1234_5678);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);

        // Undefined MDOp has no effect
        bus.start_e = 1'b1;
        bus.md_op   = 3'b111;
        bus.src_a   = 32'hDEAD_BEEF;
        tick();
        bus.start_e = 1'b0;
        tick();
        check("undef busy", {31'd0, bus.busy}, 32'd0);
        check("undef hi",   bus.hi, 32'h1234_5678);
        check("undef lo",   bus.lo, 32'hCAFE_F00D);

        // Reset pulsed mid-DIV: immediate clear, no late commit
        bus.start_e = 1'b1;
        bus.md_op   = MD_DIV;
        bus.src_a   = 32'd100;
        bus.src_b   = 32'd7;
        tick();
        bus.start_e = 1'b0;
        tick();
        tick();
        tick();
        check("rst pre busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst hi",   bus.hi, 32'd0);
        check("rst lo",   bus.lo, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("rst late busy", {31'd0, bus.busy}, 32'd0);
        check("rst late hi",   bus.hi, 32'd0);
        check("rst late lo",   bus.lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
